// File: rtl/edge_detection_top.sv
// Sobel edge detector on an RGB pixel stream, RGB444 magnitude out; EDGE_THRESHOLD_EN gives a binary edge map.
// Latency 4 I_PCLK for data, DE and syncs; no backpressure, one pixel accepted every clock.
module edge_detection_top #(
    parameter int         H_ACTIVE  = 640,
    parameter logic [7:0] THRESHOLD = 8'd64
) (
    input  logic        I_PCLK,
    input  logic        I_RST,
    input  logic [23:0] I_PIX_DATA,
    input  logic        I_VSYNC,
    input  logic        I_HSYNC,
    input  logic        I_DE,
    output logic [11:0] O_PIX_DATA,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE
);
    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int XW = AW + 1;
    localparam int YW = 12;
    localparam logic [XW-1:0] X_LIMIT = XW'(H_ACTIVE);

    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } sync_t;

    function automatic logic signed [10:0] sx(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction

    // Position counters
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          de_prev_q;

    always_comb begin
        x_d = '0;
        if (I_DE) begin
            x_d = (x_q == '1) ? x_q : x_q + 1'b1;
        end
        y_d = y_q;
        if (I_VSYNC) begin
            y_d = '0;
        end else if (de_prev_q && !I_DE && (y_q != '1)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Stage 1: luma plus position tags
    logic [15:0]   gray_sum;
    logic [7:0]    gray1_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    sync_t         s1_q, s2_q, s3_q, s4_q;

    assign gray_sum = 16'd77  * {8'd0, I_PIX_DATA[23:16]}
                    + 16'd150 * {8'd0, I_PIX_DATA[15:8]}
                    + 16'd29  * {8'd0, I_PIX_DATA[7:0]};

    // Stage 2: line buffers and 3x3 window, row 0 = y-2, column 2 = x
    logic [7:0]          lb1_q [H_ACTIVE];
    logic [7:0]          lb2_q [H_ACTIVE];
    logic [7:0]          lb1_rd, lb2_rd;
    logic [AW-1:0]       lb_idx;
    logic                lb_in_range;
    logic [2:0][2:0][7:0] win_q;
    logic [XW-1:0]       x2_q;
    logic [YW-1:0]       y2_q;

    assign lb_idx      = x1_q[AW-1:0];
    assign lb_in_range = (x1_q < X_LIMIT);

    always_comb begin
        lb1_rd = 8'd0;
        lb2_rd = 8'd0;
        if (lb_in_range) begin
            lb1_rd = lb1_q[lb_idx];
            lb2_rd = lb2_q[lb_idx];
        end
    end

    // Line buffer contents survive reset; rows 0-1 are border-masked until refilled
    always_ff @(posedge I_PCLK) begin
        if (s1_q.de && lb_in_range) begin
            lb1_q[lb_idx] <= gray1_q;
            lb2_q[lb_idx] <= lb1_rd;
        end
    end

    // Stage 3: Sobel gradients
    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
    logic               centre_ok_q;

    always_comb begin
        gx_d = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
             - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
        gy_d = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
             - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
    end

    // Stage 4: magnitude, saturation and output mapping
    logic [10:0] ax, ay;
    logic [11:0] mag;
    logic [7:0]  mag_sat;
    logic [3:0]  chan;
    logic [11:0] pix_d, pix4_q;
    logic        unused_ok;

    always_comb begin
        ax      = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        ay      = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag     = {1'b0, ax} + {1'b0, ay};
        mag_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
`ifdef EDGE_THRESHOLD_EN
        chan    = (mag_sat >= THRESHOLD) ? 4'hF : 4'h0;
`else
        chan    = mag_sat[7:4];
`endif
        pix_d   = (s3_q.de && centre_ok_q) ? {chan, chan, chan} : 12'h000;
    end

`ifdef EDGE_THRESHOLD_EN
    assign unused_ok = ^gray_sum[7:0];
`else
    assign unused_ok = ^{gray_sum[7:0], mag_sat[3:0], THRESHOLD};
`endif

    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            x_q         <= '0;
            y_q         <= '0;
            de_prev_q   <= 1'b0;
            gray1_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            s4_q        <= '0;
            win_q       <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            centre_ok_q <= 1'b0;
            pix4_q      <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            de_prev_q   <= I_DE;
            gray1_q     <= gray_sum[15:8];
            x1_q        <= x_q;
            y1_q        <= y_q;
            s1_q        <= {I_VSYNC, I_HSYNC, I_DE};
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            s4_q        <= s3_q;
            x2_q        <= x1_q;
            y2_q        <= y1_q;
            if (s1_q.de) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= gray1_q;
            end
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            centre_ok_q <= (x2_q >= XW'(2)) && (y2_q >= YW'(2));
            pix4_q      <= pix_d;
        end
    end

    assign O_PIX_DATA = pix4_q;
    assign O_VSYNC    = s4_q.vs;
    assign O_HSYNC    = s4_q.hs;
    assign O_DE       = s4_q.de;

endmodule

// File: tb/tb_edge_detection_top.sv
// Directed frames against a frame-image reference model; expectations queued at drive time, compared 4 clocks later.
module tb_edge_detection_top;
    localparam int         H   = 16;
    localparam logic [7:0] THR = 8'd64;

    logic        I_PCLK = 1'b0;
    logic        I_RST  = 1'b1;
    logic [23:0] I_PIX_DATA = '0;
    logic        I_VSYNC = 1'b0, I_HSYNC = 1'b0, I_DE = 1'b0;
    logic [11:0] O_PIX_DATA;
    logic        O_VSYNC, O_HSYNC, O_DE;

    always #5 I_PCLK = ~I_PCLK;

    edge_detection_top #(.H_ACTIVE(H), .THRESHOLD(THR)) dut (
        .I_PCLK(I_PCLK), .I_RST(I_RST), .I_PIX_DATA(I_PIX_DATA),
        .I_VSYNC(I_VSYNC), .I_HSYNC(I_HSYNC), .I_DE(I_DE),
        .O_PIX_DATA(O_PIX_DATA), .O_VSYNC(O_VSYNC), .O_HSYNC(O_HSYNC), .O_DE(O_DE)
    );

    typedef struct packed {
        logic        pix_chk;
        logic        vs;
        logic        hs;
        logic        de;
        logic [11:0] pix;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   img [0:3][0:H-1];
    int   mx = 0, my = 0;
    logic mde_prev = 1'b0;
    bit   pix_chk_en = 1'b1;

    function automatic int gray_of(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return (77 * r + 150 * g + 29 * b) >> 8;
    endfunction

    function automatic logic [11:0] map_mag(input int m);
        logic [3:0] c;
        if (m > 255) m = 255;
`ifdef EDGE_THRESHOLD_EN
        c = (m >= int'(THR)) ? 4'hF : 4'h0;
`else
        c = 4'(m >> 4);
`endif
        return {c, c, c};
    endfunction

    // Sobel centred on (x-1, y-1) of the model image
    function automatic logic [11:0] sobel(input int x, input int y);
        int t, m, b, gx, gy;
        t  = (y - 2) & 3;
        m  = (y - 1) & 3;
        b  = y & 3;
        gx = (img[t][x] + 2 * img[m][x] + img[b][x])
           - (img[t][x-2] + 2 * img[m][x-2] + img[b][x-2]);
        gy = (img[b][x-2] + 2 * img[b][x-1] + img[b][x])
           - (img[t][x-2] + 2 * img[t][x-1] + img[t][x]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return map_mag(gx + gy);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        e = sbq.pop_front();
        if (e.pix_chk) chk("pix", O_PIX_DATA, e.pix);
        chk("de", {11'd0, O_DE}, {11'd0, e.de});
        chk("hsync", {11'd0, O_HSYNC}, {11'd0, e.hs});
        chk("vsync", {11'd0, O_VSYNC}, {11'd0, e.vs});
    endtask

    task automatic step(input logic r, input logic [23:0] p,
                        input logic vs, input logic hs, input logic de);
        exp_t e;
        @(negedge I_PCLK);
        if (sbq.size() == 4) check_pop();
        I_RST = r; I_PIX_DATA = p; I_VSYNC = vs; I_HSYNC = hs; I_DE = de;
        e = '0;
        e.pix_chk = 1'b1;
        if (r) begin
            foreach (sbq[i]) sbq[i] = e;
            sbq.push_back(e);
            mx = 0; my = 0; mde_prev = 1'b0;
        end else begin
            e.vs = vs; e.hs = hs; e.de = de;
            if (de) begin
                e.pix_chk = pix_chk_en && (mx < H);
                if (mx < H) img[my & 3][mx] = gray_of(p);
                if (mx >= 2 && my >= 2 && mx < H) e.pix = sobel(mx, my);
            end
            sbq.push_back(e);
            mx = de ? mx + 1 : 0;
            if (vs) my = 0;
            else if (mde_prev && !de) my++;
            mde_prev = de;
        end
    endtask

    function automatic logic [23:0] pat(input int kind, input int x, input int l);
        case (kind)
            0: return 24'h808080;
            1: return (x < H / 2) ? 24'h000000 : 24'hFFFFFF;
            2: return (x < H / 2) ? 24'h000000 : 24'hFF0000;
            3: return (x < H / 2) ? 24'h000000 : 24'h0000FF;
            4: return (x >= l + 3) ? 24'hFFFFFF : 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic frame(input int kind, input int nlines, input int rst_line, input int long_line);
        int len;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < H + 6; c++) step(1'b0, 24'h0, 1'b1, (c < 2), 1'b0);
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? H + 4 : H;
            for (int c = 0; c < len; c++) step(1'b0, pat(kind, c, l), 1'b0, 1'b0, 1'b1);
            for (int c = 0; c < 6; c++)
                step((l == rst_line) && (c == 3), 24'h0, 1'b0, (c < 2), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 24'hABCDEF, 1'b1, 1'b1, 1'b1);
        frame(0, 6, -1, -1);
        frame(1, 6, -1, -1);
        frame(2, 5, -1, -1);
        frame(3, 5, -1, -1);
        frame(4, 8, -1, -1);
        frame(1, 8, 3, -1);
        frame(5, 6, -1, 2);
        pix_chk_en = 1'b0;
        for (int i = 0; i < 300; i++)
            step(1'b0, 24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        pix_chk_en = 1'b1;
        frame(5, 5, -1, -1);
        for (int i = 0; i < 6; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
